multicycle_control_unit: RTL

Multi-cycle control FSM for the RV32I core subset. It sequences fetch, decode, execute, memory and writeback over several cycles for each instruction. It takes the decoded opcode, funct3 and funct7 fields plus the ALU zero flag, and drives the PC, IR, register-file, ALU and memory control strobes. It sits between the instruction register/decoder and the shared datapath, and owns the single memory port handshake.

---
 rtl/riscv_ctrl_pkg.sv | 73 +++++++
 rtl/alu_ctrl_decode.sv | 55 +++++
 rtl/multicycle_control_unit.sv | 182 ++++++++++++++++++
 3 files changed

// File: rtl/riscv_ctrl_pkg.sv
// Shared definitions for the RV32I multi-cycle control unit.
// Contents: opcode constants, the FSM state encoding (4-bit, IDLE = 0),
// ALU operation encodings, ALU B-operand select encodings and the
// instruction class used by the ALU control decoder.
package riscv_ctrl_pkg;

  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;

  localparam logic [6:0] F7_BASE = 7'b0000000;
  localparam logic [6:0] F7_ALT  = 7'b0100000;

  localparam logic [2:0] F3_WORD = 3'b010;

  typedef enum logic [3:0] {
    ST_IDLE   = 4'd0,
    ST_FETCH  = 4'd1,
    ST_DECODE = 4'd2,
    ST_EXEC_R = 4'd3,
    ST_EXEC_I = 4'd4,
    ST_ADDR   = 4'd5,
    ST_MEM_RD = 4'd6,
    ST_MEM_WR = 4'd7,
    ST_WB_ALU = 4'd8,
    ST_WB_MEM = 4'd9,
    ST_BRANCH = 4'd10,
    ST_TRAP   = 4'd11
  } state_t;

  typedef enum logic [3:0] {
    ALU_ADD  = 4'd0,
    ALU_SUB  = 4'd1,
    ALU_AND  = 4'd2,
    ALU_OR   = 4'd3,
    ALU_XOR  = 4'd4,
    ALU_SLL  = 4'd5,
    ALU_SRL  = 4'd6,
    ALU_SRA  = 4'd7,
    ALU_SLT  = 4'd8,
    ALU_SLTU = 4'd9
  } alu_ctrl_t;

  typedef enum logic [1:0] {
    SRCB_RS2   = 2'd0,
    SRCB_IMM_I = 2'd1,
    SRCB_IMM_S = 2'd2
  } alu_src_b_t;

  typedef enum logic [1:0] {
    CLS_R      = 2'd0,
    CLS_IMM    = 2'd1,
    CLS_MEM    = 2'd2,
    CLS_BRANCH = 2'd3
  } op_class_t;

  // Operation selected by funct3 alone (funct7 = 0000000 flavour).
  function automatic alu_ctrl_t base_alu_op(input logic [2:0] funct3);
    case (funct3)
      3'b000:  return ALU_ADD;
      3'b001:  return ALU_SLL;
      3'b010:  return ALU_SLT;
      3'b011:  return ALU_SLTU;
      3'b100:  return ALU_XOR;
      3'b101:  return ALU_SRL;
      3'b110:  return ALU_OR;
      default: return ALU_AND;
    endcase
  endfunction

endpackage

// File: rtl/alu_ctrl_decode.sv
// Combinational ALU control decoder.
// Ports:
//   op_class  in   instruction class (R, IMM, MEM, BRANCH)
//   funct3    in   funct3 field of the IR
//   funct7    in   funct7 field of the IR
//   alu_ctrl  out  ALU operation
//   legal     out  encoding is supported for this class
module alu_ctrl_decode
  import riscv_ctrl_pkg::*;
(
  input  op_class_t   op_class,
  input  logic [2:0]  funct3,
  input  logic [6:0]  funct7,
  output alu_ctrl_t   alu_ctrl,
  output logic        legal
);

  always_comb begin
    alu_ctrl = ALU_ADD;
    legal    = 1'b0;
    case (op_class)
      CLS_R: begin
        alu_ctrl = base_alu_op(funct3);
        if (funct7 == F7_BASE) begin
          legal = 1'b1;
        end else if (funct7 == F7_ALT && (funct3 == 3'b000 || funct3 == 3'b101)) begin
          legal    = 1'b1;
          alu_ctrl = (funct3 == 3'b000) ? ALU_SUB : ALU_SRA;
        end
      end
      CLS_IMM: begin
        alu_ctrl = base_alu_op(funct3);
        case (funct3)
          3'b001: legal = (funct7 == F7_BASE);
          3'b101: begin
            legal = (funct7 == F7_BASE) || (funct7 == F7_ALT);
            if (funct7 == F7_ALT) alu_ctrl = ALU_SRA;
          end
          default: legal = 1'b1;
        endcase
      end
      CLS_MEM: begin
        alu_ctrl = ALU_ADD;
        legal    = (funct3 == F3_WORD);
      end
      CLS_BRANCH: begin
        // only BEQ (000) and BNE (001) are supported
        alu_ctrl = ALU_SUB;
        legal    = (funct3[2:1] == 2'b00);
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/multicycle_control_unit.sv
// Multi-cycle control FSM for the RV32I subset (R, OP-IMM, LW, SW, BEQ, BNE).
// Ports:
//   clkIn, resetNIn            clock, async active-low reset
//   runIn                      fetch enable, checked at instruction boundaries
//   opcodeIn/funct3In/funct7In current IR fields
//   zeroInFlag                 ALU result == 0
//   memReadyIn                 memory handshake completion
//   memReqOut/memWriteOut      memory request / write qualifier
//   irWriteOut, pcWriteOut, pcBranchOut, regWriteOut, memToRegOut
//   aluSrcBOut, aluCtrlOut     datapath controls
//   retireOut                  instruction-complete pulse
//   illegalOut                 sticky unsupported-encoding flag
//   stateOut                   state encoding for debug
//
// state   | meaning
// IDLE    | parked, waiting for runIn
// FETCH   | instruction read; IR/PC written on memReadyIn
// DECODE  | dispatch on opcode
// EXEC_R  | register-register ALU op
// EXEC_I  | register-immediate ALU op
// ADDR    | load/store address computation
// MEM_RD  | load data read
// MEM_WR  | store data write, retires on memReadyIn
// WB_ALU  | write ALU result to rd, retire
// WB_MEM  | write load data to rd, retire
// BRANCH  | compare and conditionally redirect PC, retire
// TRAP    | unsupported encoding, absorbing until reset
module multicycle_control_unit
  import riscv_ctrl_pkg::*;
(
  input  logic       clkIn,
  input  logic       resetNIn,
  input  logic       runIn,
  input  logic [6:0] opcodeIn,
  input  logic [2:0] funct3In,
  input  logic [6:0] funct7In,
  input  logic       zeroInFlag,
  input  logic       memReadyIn,
  output logic       memReqOut,
  output logic       memWriteOut,
  output logic       irWriteOut,
  output logic       pcWriteOut,
  output logic       pcBranchOut,
  output logic       regWriteOut,
  output logic       memToRegOut,
  output logic [1:0] aluSrcBOut,
  output logic [3:0] aluCtrlOut,
  output logic       retireOut,
  output logic       illegalOut,
  output logic [3:0] stateOut
);

  state_t    state_q;
  state_t    state_d;
  state_t    boundary;
  logic      illegal_q;
  op_class_t op_class;
  alu_ctrl_t dec_alu;
  logic      dec_legal;
  logic      is_load;

  always_comb begin
    case (state_q)
      ST_EXEC_I: op_class = CLS_IMM;
      ST_ADDR:   op_class = CLS_MEM;
      ST_BRANCH: op_class = CLS_BRANCH;
      default:   op_class = CLS_R;
    endcase
  end

  alu_ctrl_decode u_alu_ctrl_decode (
    .op_class (op_class),
    .funct3   (funct3In),
    .funct7   (funct7In),
    .alu_ctrl (dec_alu),
    .legal    (dec_legal)
  );

  assign is_load  = (opcodeIn == OP_LOAD);
  assign boundary = runIn ? ST_FETCH : ST_IDLE;

  always_ff @(posedge clkIn or negedge resetNIn) begin
    if (!resetNIn) begin
      state_q   <= ST_IDLE;
      illegal_q <= 1'b0;
    end else begin
      state_q <= state_d;
      if (state_d == ST_TRAP) illegal_q <= 1'b1;
    end
  end

  always_comb begin
    state_d     = state_q;
    memReqOut   = 1'b0;
    memWriteOut = 1'b0;
    irWriteOut  = 1'b0;
    pcWriteOut  = 1'b0;
    pcBranchOut = 1'b0;
    regWriteOut = 1'b0;
    memToRegOut = 1'b0;
    aluSrcBOut  = SRCB_RS2;
    aluCtrlOut  = ALU_ADD;
    retireOut   = 1'b0;
    case (state_q)
      ST_IDLE: if (runIn) state_d = ST_FETCH;
      ST_FETCH: begin
        memReqOut = 1'b1;
        if (memReadyIn) begin
          irWriteOut = 1'b1;
          pcWriteOut = 1'b1;
          state_d    = ST_DECODE;
        end
      end
      ST_DECODE: begin
        case (opcodeIn)
          OP_R:               state_d = ST_EXEC_R;
          OP_IMM:             state_d = ST_EXEC_I;
          OP_LOAD, OP_STORE:  state_d = ST_ADDR;
          OP_BRANCH:          state_d = ST_BRANCH;
          default:            state_d = ST_TRAP;
        endcase
      end
      ST_EXEC_R: begin
        aluSrcBOut = SRCB_RS2;
        aluCtrlOut = dec_alu;
        state_d    = dec_legal ? ST_WB_ALU : ST_TRAP;
      end
      ST_EXEC_I: begin
        aluSrcBOut = SRCB_IMM_I;
        aluCtrlOut = dec_alu;
        state_d    = dec_legal ? ST_WB_ALU : ST_TRAP;
      end
      ST_ADDR: begin
        aluSrcBOut = is_load ? SRCB_IMM_I : SRCB_IMM_S;
        aluCtrlOut = dec_alu;
        if (!dec_legal) state_d = ST_TRAP;
        else            state_d = is_load ? ST_MEM_RD : ST_MEM_WR;
      end
      ST_MEM_RD: begin
        memReqOut = 1'b1;
        if (memReadyIn) state_d = ST_WB_MEM;
      end
      ST_MEM_WR: begin
        memReqOut   = 1'b1;
        memWriteOut = 1'b1;
        if (memReadyIn) begin
          retireOut = 1'b1;
          state_d   = boundary;
        end
      end
      ST_WB_ALU: begin
        regWriteOut = 1'b1;
        retireOut   = 1'b1;
        state_d     = boundary;
      end
      ST_WB_MEM: begin
        regWriteOut = 1'b1;
        memToRegOut = 1'b1;
        retireOut   = 1'b1;
        state_d     = boundary;
      end
      ST_BRANCH: begin
        aluSrcBOut = SRCB_RS2;
        aluCtrlOut = dec_alu;
        if (dec_legal) begin
          // funct3[0] distinguishes BNE from BEQ
          pcBranchOut = funct3In[0] ? !zeroInFlag : zeroInFlag;
          retireOut   = 1'b1;
          state_d     = boundary;
        end else begin
          state_d = ST_TRAP;
        end
      end
      ST_TRAP: state_d = ST_TRAP;
      default: state_d = ST_IDLE;
    endcase
  end

  assign illegalOut = illegal_q;
  assign stateOut   = state_q;

endmodule
